// File: rtl/pipelined_lane_accumulator_if.sv
// Handshake bundle for the lane accumulator: beat input side and group-result output side.
interface pipelined_lane_accumulator_if #(
    parameter int WIDTH     = 3,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_data;
    logic                     in_first;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_WIDTH-1:0]     out_data;
    logic                     out_ovf;

    modport master (
        output in_valid, in_data, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/pipelined_lane_accumulator.sv
// Sums LANES unsigned operands per beat through a registered adder tree and
// accumulates beat sums into one result per first..last group.
module pipelined_lane_accumulator #(
    parameter int WIDTH     = 3,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_lane_accumulator_if.slave bus,
    output logic                        busy
);
    localparam int S  = $clog2(LANES);
    localparam int TW = WIDTH + S;
    localparam int EW = ACC_WIDTH + 1;

    logic stall;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    logic [S-1:0] vld_d, vld_q, first_d, first_q, last_d, last_q;

    always_comb begin
        vld_d   = vld_q;
        first_d = first_q;
        last_d  = last_q;
        if (!stall) begin
            vld_d[0]   = bus.in_valid;
            first_d[0] = bus.in_valid && bus.in_first;
            last_d[0]  = bus.in_valid && bus.in_last;
            for (int k = 1; k < S; k++) begin
                vld_d[k]   = vld_q[k-1];
                first_d[k] = first_q[k-1];
                last_d[k]  = last_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // Each tree level halves the operand count and grows one bit, so sums stay exact.
    for (genvar j = 0; j < S; j++) begin : g_stage
        localparam int NO = LANES >> (j + 1);
        localparam int IW = WIDTH + j;
        localparam int OW = WIDTH + j + 1;

        logic [2*NO*IW-1:0] src;
        logic [NO*OW-1:0]   sum_d, sum_q;

        if (j == 0) begin : g_src_in
            assign src = bus.in_data;
        end else begin : g_src_prev
            assign src = g_stage[j-1].sum_q;
        end

        always_comb begin
            sum_d = '0;
            for (int k = 0; k < NO; k++) begin
                sum_d[k*OW +: OW] = OW'(src[2*k*IW +: IW]) + OW'(src[(2*k+1)*IW +: IW]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
            end else if (!stall) begin
                sum_q <= sum_d;
            end
        end
    end

    logic [TW-1:0]        tree_sum;
    logic [ACC_WIDTH-1:0] acc_d, acc_q, acc_base, out_data_d, out_data_q;
    logic [EW-1:0]        sum_ext;
    logic                 ovf_d, ovf_q, out_valid_d, out_valid_q, out_ovf_d, out_ovf_q;

    assign tree_sum = g_stage[S-1].sum_q;

    // A first beat restarts both the sum and the sticky overflow before its own carry lands.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        acc_base    = first_q[S-1] ? '0 : acc_q;
        sum_ext     = EW'(acc_base) + EW'(tree_sum);
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (!stall && vld_q[S-1]) begin
            acc_d = sum_ext[ACC_WIDTH-1:0];
            ovf_d = (first_q[S-1] ? 1'b0 : ovf_q) | sum_ext[ACC_WIDTH];
            if (last_q[S-1]) begin
                out_data_d  = acc_d;
                out_ovf_d   = ovf_d;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy          = (|vld_q) || out_valid_q;
endmodule

// File: tb/tb_pipelined_lane_accumulator.sv
// Directed bench for pipelined_lane_accumulator: a default-width instance and a
// 5-bit accumulator instance for wrap/overflow behaviour.
module tb_pipelined_lane_accumulator;
    logic clk;
    logic rst_n;
    logic busy;
    logic busy5;
    int   n_checks;
    int   n_fail;

    pipelined_lane_accumulator_if #(.WIDTH(3), .LANES(4), .ACC_WIDTH(16)) bus ();
    pipelined_lane_accumulator_if #(.WIDTH(3), .LANES(4), .ACC_WIDTH(5))  bus5 ();

    pipelined_lane_accumulator #(.WIDTH(3), .LANES(4), .ACC_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    pipelined_lane_accumulator #(.WIDTH(3), .LANES(4), .ACC_WIDTH(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave),
        .busy  (busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pack(input int a, input int b, input int c, input int d);
        logic [2:0] l0, l1, l2, l3;
        l0 = 3'(a);
        l1 = 3'(b);
        l2 = 3'(c);
        l3 = 3'(d);
        return {l3, l2, l1, l0};
    endfunction

    task automatic set_beat(input logic v, input logic [11:0] d, input logic f, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_first = f;
        bus.in_last  = l;
    endtask

    task automatic set_beat5(input logic v, input logic [11:0] d, input logic f, input logic l);
        bus5.in_valid = v;
        bus5.in_data  = d;
        bus5.in_first = f;
        bus5.in_last  = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks += 4;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        if (bus.out_data !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_out_data got %0d want 0", bus.out_data); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_single_beat();
        set_beat(1'b1, pack(7, 7, 7, 7), 1'b1, 1'b1);
        step();
        set_beat(1'b0, '0, 1'b0, 1'b0);
        n_checks += 1;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy got %0b want 1", busy); end
        for (int i = 2; i <= 3; i++) begin
            n_checks += 1;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_valid edge %0d got %0b want 0", i - 1, bus.out_valid); end
            step();
        end
        n_checks += 3;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid got %0b want 1", bus.out_valid); end
        if (bus.out_data !== 16'd28) begin n_fail++; $display("[TB] FAIL single_data got %0d want 28", bus.out_data); end
        if (bus.out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ovf got %0b want 0", bus.out_ovf); end
        step();
        n_checks += 1;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drop got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_group();
        int seen;
        int seen_edge;
        logic [15:0] seen_data;
        seen = 0;
        seen_edge = 0;
        seen_data = '0;
        for (int e = 1; e <= 8; e++) begin
            case (e)
                1: set_beat(1'b1, pack(1, 2, 3, 4), 1'b1, 1'b0);
                2: set_beat(1'b1, pack(7, 0, 0, 0), 1'b0, 1'b0);
                3: set_beat(1'b1, pack(5, 5, 5, 5), 1'b0, 1'b1);
                default: set_beat(1'b0, '0, 1'b0, 1'b0);
            endcase
            step();
            if (bus.out_valid === 1'b1) begin
                seen++;
                seen_edge = e;
                seen_data = bus.out_data;
            end
        end
        n_checks += 3;
        if (seen !== 1) begin n_fail++; $display("[TB] FAIL group_count got %0d want 1", seen); end
        if (seen_data !== 16'd37) begin n_fail++; $display("[TB] FAIL group_data got %0d want 37", seen_data); end
        if (seen_edge !== 5) begin n_fail++; $display("[TB] FAIL group_latency got edge %0d want 5", seen_edge); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_beat(1'b1, pack(1, 2, 3, 4), 1'b1, 1'b1);
        step();
        set_beat(1'b1, pack(5, 5, 5, 5), 1'b1, 1'b1);
        step();
        set_beat(1'b0, '0, 1'b0, 1'b0);
        step();
        n_checks += 2;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_first_valid got %0b want 1", bus.out_valid); end
        if (bus.out_data !== 16'd10) begin n_fail++; $display("[TB] FAIL stall_first_data got %0d want 10", bus.out_data); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks += 3;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready cycle %0d got %0b want 0", i, bus.in_ready); end
            if (bus.out_data !== 16'd10) begin n_fail++; $display("[TB] FAIL stall_hold_data cycle %0d got %0d want 10", i, bus.out_data); end
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_hold_valid cycle %0d got %0b want 1", i, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks += 1;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release_ready got %0b want 1", bus.in_ready); end
        step();
        n_checks += 2;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_second_valid got %0b want 1", bus.out_valid); end
        if (bus.out_data !== 16'd20) begin n_fail++; $display("[TB] FAIL stall_second_data got %0d want 20", bus.out_data); end
        step();
        n_checks += 2;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_end_valid got %0b want 0", bus.out_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_end_busy got %0b want 0", busy); end
    endtask

    task automatic test_overflow();
        set_beat5(1'b1, pack(7, 7, 7, 7), 1'b1, 1'b0);
        step();
        set_beat5(1'b1, pack(7, 7, 7, 7), 1'b0, 1'b1);
        step();
        set_beat5(1'b0, '0, 1'b0, 1'b0);
        step();
        n_checks += 1;
        if (bus5.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_early_valid got %0b want 0", bus5.out_valid); end
        step();
        n_checks += 3;
        if (bus5.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_valid got %0b want 1", bus5.out_valid); end
        if (bus5.out_data !== 5'd24) begin n_fail++; $display("[TB] FAIL ovf_data got %0d want 24", bus5.out_data); end
        if (bus5.out_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_flag got %0b want 1", bus5.out_ovf); end
        set_beat5(1'b1, pack(1, 0, 0, 0), 1'b1, 1'b1);
        step();
        set_beat5(1'b0, '0, 1'b0, 1'b0);
        n_checks += 1;
        if (bus5.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_drop got %0b want 0", bus5.out_valid); end
        step();
        step();
        n_checks += 3;
        if (bus5.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_next_valid got %0b want 1", bus5.out_valid); end
        if (bus5.out_data !== 5'd1) begin n_fail++; $display("[TB] FAIL ovf_next_data got %0d want 1", bus5.out_data); end
        if (bus5.out_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_next_flag got %0b want 0", bus5.out_ovf); end
        step();
    endtask

    task automatic test_midgroup_reset();
        int seen;
        logic [15:0] seen_data;
        seen = 0;
        seen_data = '0;
        set_beat(1'b1, pack(3, 3, 3, 3), 1'b1, 1'b0);
        step();
        set_beat(1'b1, pack(2, 2, 2, 2), 1'b0, 1'b0);
        step();
        set_beat(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy got %0b want 0", busy); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid got %0b want 0", bus.out_valid); end
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            if (e == 1) set_beat(1'b1, pack(1, 1, 1, 1), 1'b1, 1'b1);
            else        set_beat(1'b0, '0, 1'b0, 1'b0);
            step();
            if (bus.out_valid === 1'b1) begin
                seen++;
                seen_data = bus.out_data;
            end
        end
        n_checks += 2;
        if (seen !== 1) begin n_fail++; $display("[TB] FAIL rst_result_count got %0d want 1", seen); end
        if (seen_data !== 16'd4) begin n_fail++; $display("[TB] FAIL rst_result_data got %0d want 4", seen_data); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            if (e <= 6) set_beat(1'b1, pack(e, e, e, e), 1'b1, 1'b1);
            else        set_beat(1'b0, '0, 1'b0, 1'b0);
            #1;
            n_checks += 1;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready edge %0d got %0b want 1", e, bus.in_ready); end
            step();
            if (e >= 3) begin
                n_checks += 2;
                if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_valid edge %0d got %0b want 1", e, bus.out_valid); end
                if (bus.out_data !== 16'(4 * (e - 2))) begin n_fail++; $display("[TB] FAIL b2b_data edge %0d got %0d want %0d", e, bus.out_data, 4 * (e - 2)); end
            end else begin
                n_checks += 1;
                if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_early edge %0d got %0b want 0", e, bus.out_valid); end
            end
        end
        step();
        n_checks += 1;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_tail got %0b want 0", bus.out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        set_beat(1'b0, '0, 1'b0, 1'b0);
        set_beat5(1'b0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        bus5.out_ready = 1'b1;
        #1;
        test_reset();
        step();
        step();
        rst_n = 1'b1;
        test_reset();
        test_single_beat();
        test_group();
        test_backpressure();
        test_overflow();
        test_midgroup_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
